// File: rtl/fft_pkg.sv
// Shared FFT helpers: packed complex width, round/saturate constants and the
// twiddle coefficient generator evaluated from constant arguments.
package fft_pkg;

    localparam real PI = 3.14159265358979323846;

    function automatic int cplx_width(input int real_w, input int imgn_w);
        return real_w + imgn_w;
    endfunction

    // Half of one LSB of the Q1.(tw_w-1) product scaling, for round-half-up.
    function automatic longint rnd_const(input int tw_w);
        return longint'(1) << (tw_w - 2);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    // Round to nearest, ties away from zero (matches the usual round()).
    function automatic longint round_real(input real x);
        if (x >= 0.0) begin
            return longint'($rtoi(x + 0.5));
        end
        return -longint'($rtoi(0.5 - x));
    endfunction

    function automatic longint tw_cos(input int k, input int stg, input int tw_w);
        real ang;
        real full;
        ang  = 2.0 * PI * real'(k) / real'(longint'(1) << stg);
        full = real'(sat_max(tw_w));
        return round_real($cos(ang) * full);
    endfunction

    // Forward-transform sine term is stored already negated.
    function automatic longint tw_sin(input int k, input int stg, input int tw_w);
        real ang;
        real full;
        ang  = 2.0 * PI * real'(k) / real'(longint'(1) << stg);
        full = real'(sat_max(tw_w));
        return -round_real($sin(ang) * full);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle coefficient ROM: 2^(FFT_STG-1) entries of {cos, sin}, registered read.
// Conjugation for the inverse transform is applied by the caller.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int FFT_STG  = 7,
    parameter int TW_WIDTH = 18
) (
    input  logic                    iclk,
    input  logic                    rst_n,
    input  logic [FFT_STG-2:0]      k,
    output logic [2*TW_WIDTH-1:0]   tw
);

    localparam int DEPTH = 1 << (FFT_STG - 1);

    logic [2*TW_WIDTH-1:0] tbl [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
        assign tbl[gi] = {TW_WIDTH'(tw_cos(gi, FFT_STG, TW_WIDTH)),
                          TW_WIDTH'(tw_sin(gi, FFT_STG, TW_WIDTH))};
    end

    // Registered lookup so the coefficient lines up with the first pipeline stage.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            tw <= '0;
        end else begin
            tw <= tbl[k];
        end
    end

endmodule

// File: rtl/twiddle_mul_stgx.sv
// Twiddle multiplier between radix-2 SDF stages. Difference-half samples with
// k != 0 are multiplied by exp(-/+ j*2*pi*k/2^FFT_STG); all others pass exactly.
// Fixed 3-cycle latency: S1 capture + ROM, S2 products, S3 round/sat/mux.
module twiddle_mul_stgx
    import fft_pkg::*;
#(
    parameter int FFT_STG     = 7,
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18,
    parameter int TOTAL_STAGE = 11,
    parameter int TW_WIDTH    = 18,
    localparam int CPLX_WIDTH = cplx_width(REAL_WIDTH, IMGN_WIDTH)
) (
    input  logic                    iclk,
    input  logic                    rst_n,
    input  logic                    ien,
    input  logic [TOTAL_STAGE-1:0]  iaddr,
    input  logic [CPLX_WIDTH-1:0]   idata,
    input  logic                    inv,
    input  logic                    clr_sat,
    output logic                    oen,
    output logic [TOTAL_STAGE-1:0]  oaddr,
    output logic [CPLX_WIDTH-1:0]   odata,
    output logic                    osat
);

    localparam int KW = FFT_STG - 1;
    localparam int PW = ((REAL_WIDTH > IMGN_WIDTH) ? REAL_WIDTH : IMGN_WIDTH) + TW_WIDTH;
    localparam int SW = PW + 1;
    localparam int SH = TW_WIDTH - 1;

    localparam logic signed [SW-1:0] RND     = SW'(rnd_const(TW_WIDTH));
    localparam logic signed [SW-1:0] RE_MAX  = SW'(sat_max(REAL_WIDTH));
    localparam logic signed [SW-1:0] RE_MIN  = SW'(sat_min(REAL_WIDTH));
    localparam logic signed [SW-1:0] IM_MAX  = SW'(sat_max(IMGN_WIDTH));
    localparam logic signed [SW-1:0] IM_MIN  = SW'(sat_min(IMGN_WIDTH));
    localparam logic signed [REAL_WIDTH-1:0] RE_MAX_N = REAL_WIDTH'(sat_max(REAL_WIDTH));
    localparam logic signed [REAL_WIDTH-1:0] RE_MIN_N = REAL_WIDTH'(sat_min(REAL_WIDTH));
    localparam logic signed [IMGN_WIDTH-1:0] IM_MAX_N = IMGN_WIDTH'(sat_max(IMGN_WIDTH));
    localparam logic signed [IMGN_WIDTH-1:0] IM_MIN_N = IMGN_WIDTH'(sat_min(IMGN_WIDTH));

    // Input split and bypass decision (sum half, or k = 0 where W = 1).
    logic signed [REAL_WIDTH-1:0] in_re;
    logic signed [IMGN_WIDTH-1:0] in_im;
    logic                         byp_in;

    assign in_re  = idata[CPLX_WIDTH-1:IMGN_WIDTH];
    assign in_im  = idata[IMGN_WIDTH-1:0];
    assign byp_in = ~iaddr[FFT_STG-1] | (iaddr[KW-1:0] == '0);

    // S1 registers
    logic                         en1;
    logic                         byp1;
    logic                         inv1;
    logic [TOTAL_STAGE-1:0]       addr1;
    logic signed [REAL_WIDTH-1:0] re1;
    logic signed [IMGN_WIDTH-1:0] im1;
    logic [2*TW_WIDTH-1:0]        rom_q;

    twiddle_rom #(
        .FFT_STG  (FFT_STG),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .iclk  (iclk),
        .rst_n (rst_n),
        .k     (iaddr[KW-1:0]),
        .tw    (rom_q)
    );

    // S1: capture the sample and its control alongside the ROM read.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            en1   <= 1'b0;
            byp1  <= 1'b1;
            inv1  <= 1'b0;
            addr1 <= '1;
            re1   <= '0;
            im1   <= '0;
        end else begin
            en1   <= ien;
            byp1  <= byp_in;
            inv1  <= inv;
            addr1 <= iaddr;
            re1   <= in_re;
            im1   <= in_im;
        end
    end

    // Coefficients; conjugation flips the stored sine. |sin| <= 2^(TW-1)-1, so no overflow.
    logic signed [TW_WIDTH-1:0] tw_c;
    logic signed [TW_WIDTH-1:0] tw_s_raw;
    logic signed [TW_WIDTH-1:0] tw_s;
    logic signed [PW-1:0]       m_ac;
    logic signed [PW-1:0]       m_bs;
    logic signed [PW-1:0]       m_as;
    logic signed [PW-1:0]       m_bc;

    assign tw_c     = rom_q[2*TW_WIDTH-1:TW_WIDTH];
    assign tw_s_raw = rom_q[TW_WIDTH-1:0];
    assign tw_s     = inv1 ? -tw_s_raw : tw_s_raw;

    assign m_ac = PW'(re1) * PW'(tw_c);
    assign m_bs = PW'(im1) * PW'(tw_s);
    assign m_as = PW'(re1) * PW'(tw_s);
    assign m_bc = PW'(im1) * PW'(tw_c);

    // S2 registers
    logic                         en2;
    logic                         byp2;
    logic [TOTAL_STAGE-1:0]       addr2;
    logic signed [REAL_WIDTH-1:0] re2;
    logic signed [IMGN_WIDTH-1:0] im2;
    logic signed [PW-1:0]         p_ac;
    logic signed [PW-1:0]         p_bs;
    logic signed [PW-1:0]         p_as;
    logic signed [PW-1:0]         p_bc;

    // S2: register the four partial products and carry the bypass data along.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            en2   <= 1'b0;
            byp2  <= 1'b1;
            addr2 <= '1;
            re2   <= '0;
            im2   <= '0;
            p_ac  <= '0;
            p_bs  <= '0;
            p_as  <= '0;
            p_bc  <= '0;
        end else begin
            en2   <= en1;
            byp2  <= byp1;
            addr2 <= addr1;
            re2   <= re1;
            im2   <= im1;
            p_ac  <= m_ac;
            p_bs  <= m_bs;
            p_as  <= m_as;
            p_bc  <= m_bc;
        end
    end

    // S3 arithmetic: full-precision sums, round-half-up, back to Q0.
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] shr_re;
    logic signed [SW-1:0] shr_im;

    assign sum_re = SW'(p_ac) - SW'(p_bs);
    assign sum_im = SW'(p_as) + SW'(p_bc);
    assign shr_re = (sum_re + RND) >>> SH;
    assign shr_im = (sum_im + RND) >>> SH;

    logic signed [REAL_WIDTH-1:0] sat_re;
    logic signed [IMGN_WIDTH-1:0] sat_im;
    logic                         re_ovf;
    logic                         im_ovf;
    logic                         sat_hit;

    // Clamp each component to its own width and flag the overflow.
    always_comb begin
        re_ovf = 1'b0;
        im_ovf = 1'b0;
        sat_re = shr_re[REAL_WIDTH-1:0];
        sat_im = shr_im[IMGN_WIDTH-1:0];
        if (shr_re > RE_MAX) begin
            sat_re = RE_MAX_N;
            re_ovf = 1'b1;
        end else if (shr_re < RE_MIN) begin
            sat_re = RE_MIN_N;
            re_ovf = 1'b1;
        end
        if (shr_im > IM_MAX) begin
            sat_im = IM_MAX_N;
            im_ovf = 1'b1;
        end else if (shr_im < IM_MIN) begin
            sat_im = IM_MIN_N;
            im_ovf = 1'b1;
        end
    end

    assign sat_hit = en2 & ~byp2 & (re_ovf | im_ovf);

    // S3: output registers; idle outputs follow the stage convention (0 data, all-ones address).
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            oen   <= 1'b0;
            oaddr <= '1;
            odata <= '0;
        end else begin
            oen <= en2;
            if (en2) begin
                oaddr <= addr2;
                odata <= byp2 ? {re2, im2} : {sat_re, sat_im};
            end else begin
                oaddr <= '1;
                odata <= '0;
            end
        end
    end

    // Sticky saturation flag; a clear in the same cycle as a new hit wins.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            osat <= 1'b0;
        end else if (clr_sat) begin
            osat <= 1'b0;
        end else if (sat_hit) begin
            osat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_twiddle_mul_stgx.sv
// Directed bench for twiddle_mul_stgx at FFT_STG=3, 18-bit data and twiddles.
module tb_twiddle_mul_stgx;

    localparam int CW = 36;

    logic              iclk;
    logic              rst_n;
    logic              ien;
    logic [10:0]       iaddr;
    logic [CW-1:0]     idata;
    logic              inv;
    logic              clr_sat;
    logic              oen;
    logic [10:0]       oaddr;
    logic [CW-1:0]     odata;
    logic              osat;
    logic signed [17:0] o_re;
    logic signed [17:0] o_im;

    int n_cmp;
    int n_fail;

    assign o_re = odata[35:18];
    assign o_im = odata[17:0];

    twiddle_mul_stgx #(
        .FFT_STG     (3),
        .REAL_WIDTH  (18),
        .IMGN_WIDTH  (18),
        .TOTAL_STAGE (11),
        .TW_WIDTH    (18)
    ) dut (
        .iclk    (iclk),
        .rst_n   (rst_n),
        .ien     (ien),
        .iaddr   (iaddr),
        .idata   (idata),
        .inv     (inv),
        .clr_sat (clr_sat),
        .oen     (oen),
        .oaddr   (oaddr),
        .odata   (odata),
        .osat    (osat)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    function automatic logic [CW-1:0] pk(input int re, input int im);
        return {re[17:0], im[17:0]};
    endfunction

    // Reference: hand-derived Q1.17 twiddles for N=8, round-half-up, clamp.
    function automatic void model(input int addr, input int re, input int im, input int inv_i,
                                  output int ore, output int oim);
        longint c, s, a, b, pr, pi;
        int k;
        k = addr & 3;
        if (((addr >> 2) & 1) == 0 || k == 0) begin
            ore = re;
            oim = im;
            return;
        end
        case (k)
            1: begin c = 92681;  s = -92681;  end
            2: begin c = 0;      s = -131071; end
            default: begin c = -92681; s = -92681; end
        endcase
        if (inv_i != 0) s = -s;
        a = re;
        b = im;
        pr = (a * c - b * s + 65536) >>> 17;
        pi = (a * s + b * c + 65536) >>> 17;
        if (pr > 131071) pr = 131071;
        if (pr < -131072) pr = -131072;
        if (pi > 131071) pi = 131071;
        if (pi < -131072) pi = -131072;
        ore = int'(pr);
        oim = int'(pi);
    endfunction

    task automatic idle_inputs();
        ien   = 1'b0;
        iaddr = '0;
        idata = '0;
        inv   = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (oen !== 1'b0) begin $display("FAIL reset_oen got %b exp 0", oen); n_fail++; end
        n_cmp++; if (oaddr !== 11'h7ff) begin $display("FAIL reset_oaddr got %h exp 7ff", oaddr); n_fail++; end
        n_cmp++; if (odata !== '0) begin $display("FAIL reset_odata got %h exp 0", odata); n_fail++; end
        n_cmp++; if (osat !== 1'b0) begin $display("FAIL reset_osat got %b exp 0", osat); n_fail++; end
    endtask

    task automatic test_basic();
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd6; idata = pk(1000, 0); inv = 1'b0;
        @(negedge iclk);
        idle_inputs();
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b0) begin $display("FAIL basic_early_oen got %b exp 0", oen); n_fail++; end
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b1) begin $display("FAIL basic_oen got %b exp 1", oen); n_fail++; end
        n_cmp++; if (oaddr !== 11'd6) begin $display("FAIL basic_oaddr got %0d exp 6", oaddr); n_fail++; end
        n_cmp++; if (o_re !== 18'sd0) begin $display("FAIL basic_re got %0d exp 0", o_re); n_fail++; end
        n_cmp++; if (o_im !== 18'(-1000)) begin $display("FAIL basic_im got %0d exp -1000", o_im); n_fail++; end
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b0) begin $display("FAIL basic_after_oen got %b exp 0", oen); n_fail++; end
    endtask

    task automatic test_conj_k1();
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd6; idata = pk(1000, 0); inv = 1'b1;
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd5; idata = pk(1000, 0); inv = 1'b0;
        @(negedge iclk);
        idle_inputs();
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b1 || oaddr !== 11'd6) begin $display("FAIL conj_ctl got oen=%b oaddr=%0d exp 1/6", oen, oaddr); n_fail++; end
        n_cmp++; if (o_re !== 18'sd0) begin $display("FAIL conj_re got %0d exp 0", o_re); n_fail++; end
        n_cmp++; if (o_im !== 18'sd1000) begin $display("FAIL conj_im got %0d exp 1000", o_im); n_fail++; end
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b1 || oaddr !== 11'd5) begin $display("FAIL k1_ctl got oen=%b oaddr=%0d exp 1/5", oen, oaddr); n_fail++; end
        n_cmp++; if (o_re !== 18'sd707) begin $display("FAIL k1_re got %0d exp 707", o_re); n_fail++; end
        n_cmp++; if (o_im !== 18'(-707)) begin $display("FAIL k1_im got %0d exp -707", o_im); n_fail++; end
        @(negedge iclk);
    endtask

    task automatic test_bypass();
        for (int c = 0; c < 9; c++) begin
            @(negedge iclk);
            if (c >= 3 && c < 8) begin
                n_cmp++; if (oen !== 1'b1) begin $display("FAIL byp_oen[%0d] got %b exp 1", c - 3, oen); n_fail++; end
                n_cmp++; if (oaddr !== 11'(c - 3)) begin $display("FAIL byp_oaddr got %0d exp %0d", oaddr, c - 3); n_fail++; end
                n_cmp++; if (odata !== pk(-131072, 131071)) begin $display("FAIL byp_data[%0d] got %h exp %h", c - 3, odata, pk(-131072, 131071)); n_fail++; end
            end else if (c == 8) begin
                n_cmp++; if (oen !== 1'b0) begin $display("FAIL byp_idle_oen got %b exp 0", oen); n_fail++; end
                n_cmp++; if (oaddr !== 11'h7ff) begin $display("FAIL byp_idle_oaddr got %h exp 7ff", oaddr); n_fail++; end
                n_cmp++; if (odata !== '0) begin $display("FAIL byp_idle_odata got %h exp 0", odata); n_fail++; end
            end
            if (c < 5) begin
                ien = 1'b1; iaddr = 11'(c); idata = pk(-131072, 131071); inv = c[0];
            end else begin
                idle_inputs();
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd5; idata = pk(131071, 131071); inv = 1'b0;
        @(negedge iclk);
        idle_inputs();
        @(negedge iclk);
        n_cmp++; if (osat !== 1'b0) begin $display("FAIL sat_early got %b exp 0", osat); n_fail++; end
        @(negedge iclk);
        n_cmp++; if (o_re !== 18'sd131071) begin $display("FAIL sat_re got %0d exp 131071", o_re); n_fail++; end
        n_cmp++; if (o_im !== 18'sd0) begin $display("FAIL sat_im got %0d exp 0", o_im); n_fail++; end
        n_cmp++; if (osat !== 1'b1) begin $display("FAIL sat_set got %b exp 1", osat); n_fail++; end
        repeat (3) @(negedge iclk);
        n_cmp++; if (osat !== 1'b1) begin $display("FAIL sat_sticky got %b exp 1", osat); n_fail++; end
        clr_sat = 1'b1;
        @(negedge iclk);
        clr_sat = 1'b0;
        n_cmp++; if (osat !== 1'b0) begin $display("FAIL sat_clear got %b exp 0", osat); n_fail++; end
        // New saturating sample with clr_sat high on the edge that registers it.
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd5; idata = pk(131071, 131071); inv = 1'b0;
        @(negedge iclk);
        idle_inputs();
        @(negedge iclk);
        clr_sat = 1'b1;
        @(negedge iclk);
        clr_sat = 1'b0;
        n_cmp++; if (oen !== 1'b1 || o_re !== 18'sd131071) begin $display("FAIL satclr_data got oen=%b re=%0d exp 1/131071", oen, o_re); n_fail++; end
        n_cmp++; if (osat !== 1'b0) begin $display("FAIL satclr_same got %b exp 0", osat); n_fail++; end
        @(negedge iclk);
        n_cmp++; if (osat !== 1'b0) begin $display("FAIL satclr_after got %b exp 0", osat); n_fail++; end
    endtask

    task automatic test_bubbles();
        logic v_en   [200];
        int   v_addr [200];
        int   v_re   [200];
        int   v_im   [200];
        int   sent;
        int   dre, dim, mre, mim;
        sent = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge iclk);
            if (c >= 3) begin
                if (v_en[c-3]) begin
                    n_cmp++; if (oen !== 1'b1 || oaddr !== 11'(v_addr[c-3])) begin
                        $display("FAIL bub_ctl cyc %0d got oen=%b oaddr=%0d exp 1/%0d", c, oen, oaddr, v_addr[c-3]); n_fail++; end
                    n_cmp++; if (o_re !== 18'(v_re[c-3]) || o_im !== 18'(v_im[c-3])) begin
                        $display("FAIL bub_data addr %0d got (%0d,%0d) exp (%0d,%0d)", v_addr[c-3], o_re, o_im, v_re[c-3], v_im[c-3]); n_fail++; end
                end else begin
                    n_cmp++; if (oen !== 1'b0 || oaddr !== 11'h7ff || odata !== '0) begin
                        $display("FAIL bub_gap cyc %0d got oen=%b oaddr=%h odata=%h exp 0/7ff/0", c, oen, oaddr, odata); n_fail++; end
                end
            end
            if (sent < 64 && ($urandom_range(0, 2) != 0 || c >= 120)) begin
                dre = sent * 4099 - 130000;
                dim = 120000 - sent * 3877;
                model(sent, dre, dim, (sent >> 3) & 1, mre, mim);
                ien = 1'b1; iaddr = 11'(sent); idata = pk(dre, dim); inv = sent[3];
                v_en[c] = 1'b1; v_addr[c] = sent; v_re[c] = mre; v_im[c] = mim;
                sent++;
            end else begin
                idle_inputs();
                v_en[c] = 1'b0; v_addr[c] = 0; v_re[c] = 0; v_im[c] = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd6; idata = pk(1000, 0); inv = 1'b0;
        @(negedge iclk);
        ien = 1'b1; iaddr = 11'd5; idata = pk(1000, 0); inv = 1'b0;
        @(negedge iclk);
        idle_inputs();
        @(negedge iclk);
        n_cmp++; if (oen !== 1'b1) begin $display("FAIL rstmid_pre_oen got %b exp 1", oen); n_fail++; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (oen !== 1'b0) begin $display("FAIL rstmid_oen got %b exp 0", oen); n_fail++; end
        n_cmp++; if (oaddr !== 11'h7ff) begin $display("FAIL rstmid_oaddr got %h exp 7ff", oaddr); n_fail++; end
        n_cmp++; if (odata !== '0) begin $display("FAIL rstmid_odata got %h exp 0", odata); n_fail++; end
        @(negedge iclk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge iclk);
            n_cmp++; if (oen !== 1'b0 || oaddr !== 11'h7ff) begin
                $display("FAIL rstmid_stale cyc %0d got oen=%b oaddr=%h exp 0/7ff", c, oen, oaddr); n_fail++; end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clr_sat = 1'b0;
        idle_inputs();
        repeat (3) @(negedge iclk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_conj_k1();
        test_bypass();
        test_saturation();
        test_bubbles();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_mul_stgx.md
# twiddle_mul_stgx

Twiddle-factor multiplier that sits directly downstream of each radix-2 SDF butterfly stage (`FFT_STG` ≥ 2) in the flow FFT/IFFT chain. It consumes the stage's `oen/oaddr/odata` stream and multiplies every difference-half sample by W = exp(∓j2πk/2^FFT_STG). It then presents the result with a fixed 3-cycle latency as `ien/iaddr/idata` to the next butterfly stage. Sum-half samples pass through unmodified on the same pipeline.

## Interface
- `FFT_STG`, 7: butterfly size exponent of the upstream stage; must be ≥ 2.
- `REAL_WIDTH`, 18: signed real-part width.
- `IMGN_WIDTH`, 18: signed imaginary-part width.
- `TOTAL_STAGE`, 11: log2 of FFT length; address width.
- `TW_WIDTH`, 18: signed twiddle width, format Q1.(TW_WIDTH-1).
- `iclk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ien` in 1: input sample valid.
- `iaddr` in TOTAL_STAGE: upstream output address.
- `idata` in CPLX_WIDTH: {real[CPLX_WIDTH-1:IMGN_WIDTH], imag[IMGN_WIDTH-1:0]}, two's complement.
- `inv` in 1: 1 = IFFT, which uses conjugate twiddles. Sampled per sample together with `ien`.
- `clr_sat` in 1: synchronous clear of `osat`.
- `oen` out 1: output valid.
- `oaddr` out TOTAL_STAGE: `iaddr` delayed 3 cycles.
- `odata` out CPLX_WIDTH: result, same packing as `idata`.
- `osat` out 1: sticky flag, set when any output component saturates.

## Operation
- Index: `half = iaddr[FFT_STG-1]`, `k = iaddr[FFT_STG-2:0]`.
- When `half = 0` or `k = 0`: bypass. Data passes exactly, with no rounding.
- Otherwise: output = idata × W.
- ROM contents (c = 2^(TW_WIDTH-1)-1):
  - `cos_k = round(cos(2πk/2^FFT_STG)·c)`
  - `sin_k = -round(sin(2πk/2^FFT_STG)·c)`
  - When `inv = 1`, the sin term is negated (conjugate).
- Complex product with twiddle (C, S):
  - re = a·C − b·S
  - im = a·S + b·C
  - Full-precision products and sums, width REAL_WIDTH+TW_WIDTH+1.
- Rounding and saturation:
  - Add 2^(TW_WIDTH-2), then arithmetic shift right by TW_WIDTH-1 (round-half-up).
  - Saturate each part to its own width: [−2^(W−1), 2^(W−1)−1].
- `osat` set rule:
  - Set in the cycle any valid output saturates.
  - Cleared only by reset or `clr_sat`; `clr_sat` wins over a simultaneous set.
- Gaps: `ien` may drop at any time. Bubbles propagate unchanged, and no sample is dropped or duplicated.

## Timing
- Pipeline, fixed 3-cycle latency for every sample, bypass or multiplied:
  - **S1:** register input data, `half`, `k`, `inv`, `iaddr`, `ien`; registered ROM read addressed by `iaddr`.
  - **S2:** register the four products plus the delayed bypass data.
  - **S3:** add, round, saturate, and bypass-mux into the output registers.
- `oen` rises exactly 3 rising edges after the edge that samples `ien = 1`.
- `oaddr` and `odata` are valid in the same cycle as `oen`.
- Idle output (`oen = 0`): `odata = 0`, `oaddr` = all ones. This matches the stage idle convention.
- Reset values: `oen = 0`, `odata = 0`, `oaddr` = all ones, `osat = 0`; all pipeline valids cleared.
- Reset asserted mid-stream: in-flight samples are discarded, and outputs go to reset values immediately (asynchronously).
- First valid output after reset release comes 3 edges after the first sampled `ien`.
- No back-pressure; the block accepts one sample per cycle indefinitely.

## Structure
- Shared `fft_pkg` include holds:
  - CPLX_WIDTH derivation,
  - the rounding-constant and saturation-limit functions,
  - the twiddle ROM generation function ($cos/$sin at elaboration).
- One sub-module, `twiddle_rom`:
  - depth 2^(FFT_STG-1), registered output {cos, sin} of 2·TW_WIDTH bits,
  - conjugation applied outside the ROM.
- Top level contains the valid/address delay line, multipliers, adders, round/saturate, and the `osat` register.

## Test plan
- **Defaults for the first three tests:** FFT_STG=3, REAL=IMGN=TW=18. Input (1000,0), iaddr=6 (k=2), inv=0 -> 3 cycles later `odata` = (0,−1000), `oaddr` = 6, `oen` = 1.
- **Conjugate and k=1:**
  - Same input with inv=1 -> (0,+1000).
  - Input (1000,0) at iaddr=5 (k=1), inv=0 -> (707,−707).
- **Bypass:** iaddr 0–4 with data (−131072,131071) -> identical data out. Also check `oaddr`, idle `oaddr` = all ones, and `odata` = 0.
- **Saturation:** input (131071,131071) at k=1 -> (131071,0), `osat` = 1 and stays 1. Then pulse `clr_sat` -> `osat` = 0. Also pulse `clr_sat` in the same cycle as a new saturation -> `osat` = 0.
- **Bubbles:** random `ien` pattern over 64 addresses -> output sequence equals a reference model sample-for-sample, with identical gap pattern shifted by 3 cycles.
- **Reset mid-stream:** assert `rst_n` low with 2 samples in flight -> `oen` = 0, `oaddr` = all ones immediately. After release, no stale outputs appear.
